osc_reset_sequencer: RTL and testbench
======================================

// Module: osc_reset_sequencer
// PURPOSE
//   Downstream consumer of the on-chip RC oscillator clock (RCOSC_25_50MHZ CLKOUT). Runs on that clock
//   and turns raw power-up, PLL lock and push-button reset into staged, glitch-free resets.
//   Peripherals come out of reset first, the CPU core last. Any lock loss or button press re-asserts both.
// PARAMETERS
//   HOLD_CYCLES        64    cycles both resets stay asserted after reset deasserts / button release
//   LOCK_STABLE_CYCLES 1024  consecutive cycles pll_lock must be high before release begins
//   STAGE_GAP          16    cycles between periph_reset and core_reset deassertion
//   SYNC_STAGES        2     flops in each input synchronizer (>=2)
//   DEBOUNCE_CYCLES    256   button stable time, used only with OSC_RST_DEBOUNCE_EN
// PORTS
//   clk           in   1  oscillator clock (RCOSC CLKOUT)
//   reset         in   1  synchronous, active-high reset
//   pll_lock      in   1  asynchronous PLL lock flag
//   button_n      in   1  asynchronous push-button, active low
//   periph_reset  out  1  registered, active-high peripheral reset
//   core_reset    out  1  registered, active-high CPU core reset
//   ready         out  1  registered; high only in RUN
// BEHAVIOUR
//   One clock, synchronous active-high reset. During reset: state=HOLD, cnt=0, sync flops=0,
//   periph_reset=1, core_reset=1, ready=0.
//   pll_lock and ~button_n pass through SYNC_STAGES-flop synchronizers -> lock_s, btn_s (SYNC_STAGES latency).
//   cnt width = $clog2(max(HOLD_CYCLES,LOCK_STABLE_CYCLES,STAGE_GAP,DEBOUNCE_CYCLES)+1); saturates, never wraps.
//   States:
//     HOLD:   resets=1. cnt counts while btn_s=0; btn_s=1 clears cnt. cnt==HOLD_CYCLES-1 -> WAIT_LOCK, cnt=0.
//     WAIT_LOCK: resets=1. lock_s=1 increments cnt, lock_s=0 clears cnt. cnt==LOCK_STABLE_CYCLES-1 with
//             lock_s=1 -> STAGE, cnt=0, periph_reset<=0 on same edge.
//     STAGE:  periph_reset=0, core_reset=1. cnt==STAGE_GAP-1 -> RUN, core_reset<=0, ready<=1 on same edge.
//     RUN:    all released; stays until an abort event.
//   Abort (evaluated every cycle, all states): btn_s=1 -> HOLD; else lock_s=0 in STAGE/RUN -> WAIT_LOCK.
//     On abort edge: periph_reset<=1, core_reset<=1, ready<=0, cnt<=0. Button has priority over lock loss.
//   Resets assert in 1 cycle (after sync latency), deassert only via full sequence; no output glitches.
//   lock_s toggling in WAIT_LOCK restarts the stability count; never partial credit.
//   Re-asserting reset mid-sequence returns to reset values on the next edge regardless of state.
// CONFIGURATION
//   OSC_RST_DEBOUNCE_EN defined: btn_s feeds a debouncer; its output changes only after the raw
//     synchronized value is stable DEBOUNCE_CYCLES consecutive cycles (reset value 0). Adds that latency.
//   Not defined: btn_s used directly; DEBOUNCE_CYCLES ignored; no debounce counter instantiated.
// STRUCTURE
//   Package osc_rst_pkg: state enum {HOLD, WAIT_LOCK, STAGE, RUN} (2-bit), counter-width function.
//   Sub-module osc_rst_sync: SYNC_STAGES-deep synchronizer, instantiated twice (pll_lock, button_n).
//   Debouncer and FSM stay in this module.
// TESTING (HOLD=4, LOCK_STABLE=8, STAGE_GAP=2, SYNC=2, debounce off unless stated)
//   Clean power-up: pll_lock=1, button_n=1 from t0, reset low at edge 0 -> periph_reset falls edge 12,
//     core_reset and ready change edge 14; all resets high before that.
//   Lock glitch in WAIT_LOCK: pll_lock low 1 cycle at edge 8 -> count restarts; periph release delayed
//     by glitch position +sync latency; check no early release.
//   Lock loss in RUN: pll_lock falls -> both resets high and ready low exactly SYNC_STAGES+1 edges later;
//     relock -> full 8+2 cycle sequence repeats.
//   Button in STAGE with simultaneous lock loss -> state HOLD (not WAIT_LOCK); release after button
//     deassert + 4 + 8 + 2 cycles.
//   reset pulsed 1 cycle while in RUN -> next edge: all outputs at reset values, state HOLD.
//   With OSC_RST_DEBOUNCE_EN, DEBOUNCE=4: 3-cycle button pulse ignored; 5-cycle pulse aborts RUN.

Source files
------------

// File: rtl/osc_rst_pkg.sv
// Shared types and helpers for the oscillator reset sequencer.
// Holds the sequencer state encoding and the counter-width function.
package osc_rst_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    STAGE     = 2'd2,
    RUN       = 2'd3
  } state_e;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    cnt_width = (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/osc_rst_sync.sv
// Multi-flop synchronizer for one asynchronous level input.
// Clears to 0 under synchronous reset.
module osc_rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw level one flop deeper each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer chain register.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/osc_reset_sequencer.sv
// Staged periph/core reset release from PLL lock and push-button.
// Define OSC_RST_DEBOUNCE_EN to debounce the synchronized button.
module osc_reset_sequencer
  import osc_rst_pkg::*;
#(
  parameter int HOLD_CYCLES        = 64,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP          = 16,
  parameter int SYNC_STAGES        = 2,
  parameter int DEBOUNCE_CYCLES    = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_lock,
  input  logic button_n,
  output logic periph_reset,
  output logic core_reset,
  output logic ready
);

  localparam int CW = cnt_width(HOLD_CYCLES,
    LOCK_STABLE_CYCLES, STAGE_GAP, DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

  logic lock_s;
  logic btn_raw;
  logic btn_s;

  osc_rst_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  osc_rst_sync #(.STAGES(SYNC_STAGES)) u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     (~button_n),
    .q     (btn_raw)
  );

`ifdef OSC_RST_DEBOUNCE_EN
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_db_q;
  logic          btn_db_d;
  logic [CW-1:0] db_cnt_q;
  logic [CW-1:0] db_cnt_d;

  // Follow the raw button only after it differs for the full window.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_raw != btn_db_q) begin
      if (db_cnt_q == DB_LAST) btn_db_d = btn_raw;
      else                     db_cnt_d = db_cnt_q + CW'(1);
    end
  end

  // Debouncer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_db_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      btn_db_q <= btn_db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign btn_s = btn_db_q;
`else
  assign btn_s = btn_raw;
`endif

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          periph_reset_q;
  logic          periph_reset_d;
  logic          core_reset_q;
  logic          core_reset_d;
  logic          ready_q;
  logic          ready_d;

  // Next state, counter and outputs; aborts override the sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    unique case (state_q)
      HOLD: begin
        if (btn_s) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = STAGE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      STAGE: begin
        if (cnt_q == GAP_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase
    if (btn_s) begin
      state_d = HOLD;
      cnt_d   = '0;
    end else if (!lock_s &&
                 (state_q == STAGE || state_q == RUN)) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end
    periph_reset_d = !(state_d == STAGE || state_d == RUN);
    core_reset_d   = (state_d != RUN);
    ready_d        = (state_d == RUN);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= HOLD;
      cnt_q          <= '0;
      periph_reset_q <= 1'b1;
      core_reset_q   <= 1'b1;
      ready_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      periph_reset_q <= periph_reset_d;
      core_reset_q   <= core_reset_d;
      ready_q        <= ready_d;
    end
  end

  assign periph_reset = periph_reset_q;
  assign core_reset   = core_reset_q;
  assign ready        = ready_q;

endmodule

// File: tb/tb_osc_reset_sequencer.sv
// Directed bench for osc_reset_sequencer (HOLD=4 LOCK=8 GAP=2).
// Edge numbers count from the last edge that samples reset high.
module tb_osc_reset_sequencer;
  import osc_rst_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pll_lock = 1'b1;
  logic button_n = 1'b1;
  logic periph_reset;
  logic core_reset;
  logic ready;

  int n_chk = 0;
  int n_err = 0;
  int e = 0;

  osc_reset_sequencer #(
    .HOLD_CYCLES        (4),
    .LOCK_STABLE_CYCLES (8),
    .STAGE_GAP          (2),
    .SYNC_STAGES        (2),
    .DEBOUNCE_CYCLES    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .button_n     (button_n),
    .periph_reset (periph_reset),
    .core_reset   (core_reset),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @e%0d: got %0h want %0h",
               tag, e, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int t);
    while (e < t) tick();
  endtask

  task automatic outs(input string tag,
                      input logic p,
                      input logic c,
                      input logic r);
    check({tag, ".periph"}, 32'(periph_reset), 32'(p));
    check({tag, ".core"}, 32'(core_reset), 32'(c));
    check({tag, ".ready"}, 32'(ready), 32'(r));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    e = 0;
    reset = 1'b0;
  endtask

  initial begin
    tick();
    tick();

    do_reset();
    outs("rst", 1'b1, 1'b1, 1'b0);
    check("rst.state", 32'(dut.state_q), 32'(HOLD));
    for (int k = 1; k <= 15; k++) begin
      run_to(k);
      outs("pwrup", k < 12, k < 14, k >= 14);
    end

    do_reset();
    run_to(7);
    pll_lock = 1'b0;
    run_to(8);
    pll_lock = 1'b1;
    run_to(12);
    outs("glitch12", 1'b1, 1'b1, 1'b0);
    run_to(17);
    outs("glitch17", 1'b1, 1'b1, 1'b0);
    run_to(18);
    outs("glitch18", 1'b0, 1'b1, 1'b0);
    run_to(19);
    outs("glitch19", 1'b0, 1'b1, 1'b0);
    run_to(20);
    outs("glitch20", 1'b0, 1'b0, 1'b1);

    run_to(22);
    pll_lock = 1'b0;
    run_to(24);
    outs("loss24", 1'b0, 1'b0, 1'b1);
    run_to(25);
    outs("loss25", 1'b1, 1'b1, 1'b0);
    check("loss.state", 32'(dut.state_q), 32'(WAIT_LOCK));
    run_to(26);
    pll_lock = 1'b1;
    run_to(35);
    outs("relock35", 1'b1, 1'b1, 1'b0);
    run_to(36);
    outs("relock36", 1'b0, 1'b1, 1'b0);
    run_to(37);
    outs("relock37", 1'b0, 1'b1, 1'b0);
    run_to(38);
    outs("relock38", 1'b0, 1'b0, 1'b1);

`ifndef OSC_RST_DEBOUNCE_EN
    do_reset();
    run_to(10);
    button_n = 1'b0;
    pll_lock = 1'b0;
    run_to(12);
    outs("btn12", 1'b0, 1'b1, 1'b0);
    check("btn12.state", 32'(dut.state_q), 32'(STAGE));
    run_to(13);
    outs("btn13", 1'b1, 1'b1, 1'b0);
    check("btn13.state", 32'(dut.state_q), 32'(HOLD));
    run_to(14);
    button_n = 1'b1;
    pll_lock = 1'b1;
    run_to(19);
    check("btn19.state", 32'(dut.state_q), 32'(HOLD));
    run_to(20);
    check("btn20.state", 32'(dut.state_q), 32'(WAIT_LOCK));
    run_to(27);
    outs("btn27", 1'b1, 1'b1, 1'b0);
    run_to(28);
    outs("btn28", 1'b0, 1'b1, 1'b0);
    run_to(29);
    outs("btn29", 1'b0, 1'b1, 1'b0);
    run_to(30);
    outs("btn30", 1'b0, 1'b0, 1'b1);
`endif

    run_to(e + 2);
    outs("prerst", 1'b0, 1'b0, 1'b1);
    do_reset();
    outs("rstrun", 1'b1, 1'b1, 1'b0);
    check("rstrun.state", 32'(dut.state_q), 32'(HOLD));
    check("rstrun.cnt", 32'(dut.cnt_q), 32'd0);
    run_to(11);
    outs("rerun11", 1'b1, 1'b1, 1'b0);
    run_to(12);
    outs("rerun12", 1'b0, 1'b1, 1'b0);
    run_to(14);
    outs("rerun14", 1'b0, 1'b0, 1'b1);

`ifdef OSC_RST_DEBOUNCE_EN
    run_to(20);
    button_n = 1'b0;
    run_to(23);
    button_n = 1'b1;
    run_to(30);
    outs("db3", 1'b0, 1'b0, 1'b1);
    button_n = 1'b0;
    run_to(35);
    button_n = 1'b1;
    run_to(36);
    outs("db5.36", 1'b0, 1'b0, 1'b1);
    run_to(37);
    outs("db5.37", 1'b1, 1'b1, 1'b0);
    check("db5.state", 32'(dut.state_q), 32'(HOLD));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
